// File: rtl/rca_slice_sequencer.sv
// ---------------------------------------------------------------------------
// rca_slice_sequencer
//
// Digit-serial adder controller. A WIDTH-bit addition is performed by one
// 4-bit ripple-carry adder (RCA4bit) over NSLICES = WIDTH/4 clock cycles,
// least significant slice first. The carry between slices is kept in a
// register, so the longest combinational path is a single 4-bit adder.
//
// Optional feature macro: SEQ_SUB_EN
//   When defined, an extra input i_sub selects subtraction (a - b). In that
//   case b is stored inverted and the carry register starts at 1.
//
// Ports (rca_slice_sequencer):
//   i_clk    in   1      clock, rising edge
//   i_rst    in   1      synchronous active-high reset
//   i_start  in   1      start request, only looked at in IDLE
//   i_a      in   WIDTH  operand A, captured on the accepting edge
//   i_b      in   WIDTH  operand B, captured on the accepting edge
//   i_cin    in   1      carry-in for slice 0, captured on the accepting edge
//   i_sub    in   1      (SEQ_SUB_EN only) 1 = compute a - b
//   o_busy   out  1      high while RUN or DONE
//   o_done   out  1      one-cycle pulse, o_sum/o_cout final in that cycle
//   o_sum    out  WIDTH  result, held until the next accepted start
//   o_cout   out  1      carry out of the top slice, held like o_sum
//
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// RCA4bit: plain 4-bit ripple-carry adder built from four full adders.
// Ports:
//   i_a, i_b  in   4   addends
//   i_cin     in   1   carry in
//   o_sum     out  4   sum
//   o_cout    out  1   carry out of bit 3
// ---------------------------------------------------------------------------
module RCA4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_carry;
    logic [3:0] w_sum;

    // Four chained full adders; carry ripples from bit 0 to bit 3.
    always_comb begin
        w_carry    = 5'b0_0000;
        w_sum      = 4'b0000;
        w_carry[0] = i_cin;
        for (int i = 0; i < 4; i++) begin
            w_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_sum  = w_sum;
    assign o_cout = w_carry[4];

endmodule

module rca_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SEQ_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int NSLICES = WIDTH / 4;
    // Keep the counter at least one bit wide even for a single slice.
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_c_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [3:0]       w_rca_sum;
    logic             w_rca_cout;
    logic [WIDTH-1:0] w_sum_shift;

`ifdef SEQ_SUB_EN
    assign w_sub = i_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Operand B and initial carry as loaded at start: a - b is a + ~b + 1.
    always_comb begin
        w_b_load = i_b;
        w_c_load = i_cin;
        if (w_sub) begin
            w_b_load = ~i_b;
            w_c_load = 1'b1;
        end else begin
            w_b_load = i_b;
            w_c_load = i_cin;
        end
    end

    // The only adder in the design: it always works on the low slice of the
    // shift registers together with the stored inter-slice carry.
    RCA4bit u_rca (
        .i_a    (r_a_sh[3:0]),
        .i_b    (r_b_sh[3:0]),
        .i_cin  (r_c_q),
        .o_sum  (w_rca_sum),
        .o_cout (w_rca_cout)
    );

    // New slice enters the result at the MSB end; after NSLICES shifts the
    // first slice computed has reached bits [3:0].
    generate
        if (WIDTH == 4) begin : g_sum_one_slice
            assign w_sum_shift = w_rca_sum;
        end else begin : g_sum_multi_slice
            assign w_sum_shift = {w_rca_sum, r_sum[WIDTH-1:4]};
        end
    endgenerate

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_c_q   <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= w_b_load;
                        r_c_q   <= w_c_load;
                        r_cnt   <= {CW{1'b0}};
                        r_sum   <= {WIDTH{1'b0}};
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_sum  <= w_sum_shift;
                    r_a_sh <= r_a_sh >> 4;
                    r_b_sh <= r_b_sh >> 4;
                    r_c_q  <= w_rca_cout;
                    r_busy <= 1'b1;
                    if (r_cnt == LAST_SLICE) begin
                        // Final slice: its carry is the carry of the whole word.
                        r_cout  <= w_rca_cout;
                        r_cnt   <= {CW{1'b0}};
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        r_done  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end

                S_DONE: begin
                    // start is not looked at here; the next request is only
                    // sampled once back in IDLE.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Self-checking bench for rca_slice_sequencer (WIDTH = 16).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_rca_slice_sequencer;

    localparam int WIDTH   = 16;
    localparam int NSLICES = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_assert;
    int n_fail;

    rca_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
`ifdef SEQ_SUB_EN
        .i_sub   (sub),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, no slicing.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [WIDTH-1:0] esum, output logic ecout);
        int unsigned ua, ub, r;
        ua = ma;
        ub = mb;
        if (msub) begin
            r     = (ua - ub) & 32'h0000_FFFF;
            esum  = r[WIDTH-1:0];
            ecout = (ua >= ub);
        end else begin
            r     = ua + ub + (mcin ? 32'd1 : 32'd0);
            esum  = r[WIDTH-1:0];
            ecout = r[WIDTH];
        end
    endtask

    // Called at a falling edge with the DUT idle. Start is sampled at the next
    // rising edge (edge 0). Optionally a stray start pulse is presented so
    // that it is sampled at edge ign_edge. Returns at the falling edge after
    // edge NSLICES+1 (first IDLE cycle).
    task automatic do_op(input string tag, input logic [WIDTH-1:0] oa,
                         input logic [WIDTH-1:0] ob, input logic ocin,
                         input logic osub, input int ign_edge);
        logic [WIDTH-1:0] esum;
        logic             ecout;
        model(oa, ob, ocin, osub, esum, ecout);
        start = 1'b1; a = oa; b = ob; cin = ocin; sub = osub;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
`ifndef SEQ_SUB_EN
        sub = 1'b0;
`endif
        chk({tag, " busy after edge0"}, 32'(busy), 32'd1);
        chk({tag, " done after edge0"}, 32'(done), 32'd0);
        for (int k = 1; k <= NSLICES; k++) begin
            if (k == ign_edge) begin
                start = 1'b1; a = 16'hAAAA;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk({tag, " busy in run"}, 32'(busy), 32'd1);
            if (k < NSLICES) begin
                chk({tag, " done early"}, 32'(done), 32'd0);
            end else begin
                chk({tag, " done pulse"}, 32'(done), 32'd1);
                chk({tag, " sum"}, 32'(sum), 32'(esum));
                chk({tag, " cout"}, 32'(cout), 32'(ecout));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, " busy back low"}, 32'(busy), 32'd0);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " sum held"}, 32'(sum), 32'(esum));
        chk({tag, " cout held"}, 32'(cout), 32'(ecout));
    endtask

    initial begin
        logic [WIDTH-1:0] esum;
        logic             ecout;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum",  32'(sum),  32'd0);
        chk("reset cout", 32'(cout), 32'd0);

        // Directed cases
        do_op("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        chk("literal 5555", 32'(sum), 32'h5555);
        do_op("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        chk("literal carry chain", 32'({cout, sum}), 32'h1_0000);
        do_op("add FFFF+FFFF+1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle hold sum", 32'(sum), 32'hFFFF);
            chk("idle hold cout", 32'(cout), 32'd1);
            chk("idle busy", 32'(busy), 32'd0);
        end
        // Stray start sampled at edge 2 must be ignored
        do_op("ignore start", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 2);
        chk("literal 1010", 32'(sum), 32'h1010);
        // Nothing was queued by the stray start
        @(posedge clk);
        @(negedge clk);
        chk("no queued op", 32'(busy), 32'd0);

        // Reset at edge 2 of an operation
        start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum",  32'(sum),  32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        do_op("after abort", 16'h8001, 16'h8002, 1'b1, 1'b0, 0);

`ifdef SEQ_SUB_EN
        do_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        chk("literal FFFE", 32'({cout, sum}), 32'h0_FFFE);
        do_op("sub 7-5", 16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        chk("literal 0002", 32'({cout, sum}), 32'h1_0002);
`endif

        // Random operations back to back at the minimum issue interval
        for (int n = 0; n < 25; n++) begin
            logic rs;
            rs = 1'($urandom);
`ifndef SEQ_SUB_EN
            rs = 1'b0;
`endif
            do_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rs, 0);
        end
        model(16'h0000, 16'h0000, 1'b1, 1'b0, esum, ecout);
        do_op("zero plus cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        chk("zero plus cin result", 32'({cout, sum}), 32'({ecout, esum}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rca_slice_sequencer.md
# rca_slice_sequencer

Multi-cycle, digit-serial adder controller that sits directly upstream of the 4-bit ripple-carry adder (`RCA4bit`). It accepts WIDTH-bit operands with a start pulse and feeds them to one internal `RCA4bit` instance one 4-bit slice per cycle, LSB slice first. Between cycles it holds the inter-slice carry in a register. It assembles the full sum and carry-out and signals completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 16: operand/sum width. Must be a multiple of 4 and at least 4. NSLICES = WIDTH/4.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a new addition. Sampled only in IDLE.
- `a`  in  WIDTH: operand A, captured on the accepting edge.
- `b`  in  WIDTH: operand B, captured on the accepting edge.
- `cin`  in  1: carry-in for slice 0, captured on the accepting edge.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; `sum`/`cout` are valid in that cycle.
- `sum`  out  WIDTH: result register. Holds its value until the next accepted start.
- `cout`  out  1: carry out of the top slice. Held like `sum`.

## Operation
- Datapath:
  - Operand shift registers `a_sh` and `b_sh` (WIDTH bits) are captured at start.
  - Carry register `c_q` is loaded with `cin` at start.
  - Slice counter covers 0..NSLICES-1.
  - The `RCA4bit` inputs are `a_sh[3:0]`, `b_sh[3:0]` and `c_q`.
- Each RUN edge:
  - The adder's 4-bit sum shifts into `sum` from the MSB end (`sum <= {rca_sum, sum[WIDTH-1:4]}`).
  - `a_sh` and `b_sh` shift right by 4.
  - `c_q <= rca_cout`.
  - The counter increments.
- After NSLICES shifts, slice 0's result sits in `sum[3:0]`. On the last RUN edge `cout <= rca_cout`.
- FSM:
  - IDLE → RUN on `start`: operands latched, counter cleared, `sum` cleared. If `start` is low, stay in IDLE.
  - RUN → RUN while counter < NSLICES-1.
  - RUN → DONE on the edge that processes slice NSLICES-1.
  - DONE → IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued, and operands are not re-sampled.
- Arithmetic is modulo 2^WIDTH. `cout` is bit WIDTH of a + b + cin.
- Reset puts the FSM in IDLE and clears `sum`, `cout`, `busy`, `done`, `c_q`, the counter and the shift registers to 0.
- `rst` mid-operation aborts the operation. Partial results are discarded and outputs read 0 on the cycle after the reset edge.
- `rst` has priority over `start` on the same edge.

## Timing
- Edge 0 samples `start=1` in IDLE. `busy` is high from the cycle after edge 0.
- Edges 1..NSLICES process slices 0..NSLICES-1.
- `done` is high for exactly one cycle, the cycle after edge NSLICES (for WIDTH=16, after edge 4). `sum` and `cout` are final in that cycle.
- The next `start` can be accepted at the edge ending the first IDLE cycle, i.e. edge NSLICES+2. Minimum issue interval is NSLICES+2 cycles.
- The combinational path is one `RCA4bit` plus register setup. No path spans the full WIDTH.
- `a`, `b` and `cin` need to be stable only at the accepting edge.

## Configuration
- `SEQ_SUB_EN`:
  - When defined, adds an input port `sub` (1 bit), captured with the operands at start.
    - `sub=1`: `b` is stored inverted and `c_q` is loaded with 1 (`cin` ignored). The result is a − b mod 2^WIDTH, and `cout` = 1 means no borrow (a ≥ b unsigned).
    - `sub=0`: identical to the build without the macro.
  - When not defined: no `sub` port, addition only.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start at edge 0 → `done` high after edge 4, `sum`=0x5555, `cout`=0, `busy` low again after edge 5.
- a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1. The carry propagates through all four slices via `c_q`.
- a=0xFFFF, b=0xFFFF, cin=1 → `sum`=0xFFFF, `cout`=1. Then the outputs hold across 3 idle cycles with `start` low.
- Start a=0x0F0F, b=0x0101. Pulse `start` with a=0xAAAA at edge 2 (RUN) → ignored; result `sum`=0x1010, `done` at the nominal cycle.
- Assert `rst` at edge 2 of an operation → the cycle after reads `busy`=0, `done`=0, `sum`=0, `cout`=0. A new start at the next edge completes normally.
- With `SEQ_SUB_EN`:
  - `sub`=1, a=0x0005, b=0x0007 → `sum`=0xFFFE, `cout`=0.
  - `sub`=1, a=0x0007, b=0x0005 → `sum`=0x0002, `cout`=1.
